// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
// Channel 1 (CH_MEM) is the memory/LSU path, channel 2 (CH_ALU) the ALU path.
package demux_pkg;

  localparam int CH_DEPTH = 2;
  localparam int CNT_W    = 16;

  typedef enum logic {
    CH_ALU = 1'b0,
    CH_MEM = 1'b1
  } ch_sel_e;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'(CH_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Simultaneous push and pop leaves occupancy unchanged.
  function automatic occ_t occ_next(input occ_t occ, input logic push, input logic pop);
    occ_t nxt;
    nxt = occ;
    case ({push, pop})
      2'b10:   nxt = occ + 2'd1;
      2'b01:   nxt = occ - 2'd1;
      default: nxt = occ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/chan_fifo2.sv
// Two-entry circular buffer used as one output channel of demux1x2.
// Head entry is always presented on rdata, even when empty (0 after reset).
module chan_fifo2
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [CH_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  occ_t                  occ;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (occ == OCC_FULL);
  assign empty   = (occ == OCC_EMPTY);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Entries are cleared on reset so an empty channel shows a deterministic 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= OCC_EMPTY;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ_next(occ, push_ok, pop_ok);
    end
  end

endmodule

// File: rtl/demux1x2.sv
// Routes one producer stream to the memory channel (in_sel=1) or ALU channel (in_sel=0).
// Define DEMUX1X2_CNT_EN to add per-channel saturating push counters (cnt1, cnt2, cnt_clr).
module demux1x2
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [DATA_WIDTH-1:0] out2_data,
  output logic                  out2_valid,
  input  logic                  out2_ready
`ifdef DEMUX1X2_CNT_EN
  ,
  output logic [CNT_W-1:0]      cnt1,
  output logic [CNT_W-1:0]      cnt2,
  input  logic                  cnt_clr
`endif
);

  ch_sel_e sel;
  logic    full1, full2;
  logic    empty1, empty2;
  logic    push1, push2;
  logic    pop1, pop2;

  assign sel = ch_sel_e'(in_sel);

  // Ready looks only at registered occupancy of the selected channel, so a pop
  // in the same cycle never frees a slot for the producer.
  assign in_ready = (sel == CH_MEM) ? ~full1 : ~full2;

  assign push1 = in_valid & in_ready & (sel == CH_MEM);
  assign push2 = in_valid & in_ready & (sel == CH_ALU);

  assign out1_valid = ~empty1;
  assign out2_valid = ~empty2;
  assign pop1       = out1_valid & out1_ready;
  assign pop2       = out2_valid & out2_ready;

  chan_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_ch1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .wdata (in_data),
    .pop   (pop1),
    .rdata (out1_data),
    .full  (full1),
    .empty (empty1)
  );

  chan_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_ch2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push2),
    .wdata (in_data),
    .pop   (pop2),
    .rdata (out2_data),
    .full  (full2),
    .empty (empty2)
  );

`ifdef DEMUX1X2_CNT_EN
  // Clear wins over a simultaneous push; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (cnt_clr) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (push1 && (cnt1 != CNT_MAX)) begin
        cnt1 <= cnt1 + 1'b1;
      end
      if (push2 && (cnt2 != CNT_MAX)) begin
        cnt2 <= cnt2 + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux1x2.sv
// Self-checking bench for demux1x2: directed scenarios plus randomized traffic
// compared against queue-based channel models.
module tb_demux1x2;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out2_data;
  logic        out2_valid;
  logic        out2_ready;
`ifdef DEMUX1X2_CNT_EN
  logic [15:0] cnt1;
  logic [15:0] cnt2;
  logic        cnt_clr;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int          m_cnt1 = 0;
  int          m_cnt2 = 0;

  demux1x2 #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
`ifdef DEMUX1X2_CNT_EN
    ,
    .cnt1       (cnt1),
    .cnt2       (cnt2),
    .cnt_clr    (cnt_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and apply the channel rules to the model queues.
  task automatic step();
    bit do_push, pop1, pop2, clr;
    do_push = in_valid && (in_sel ? (q1.size() < 2) : (q2.size() < 2));
    pop1    = (q1.size() > 0) && out1_ready;
    pop2    = (q2.size() > 0) && out2_ready;
    clr     = 1'b0;
`ifdef DEMUX1X2_CNT_EN
    clr = cnt_clr;
`endif
    @(posedge clk);
    if (pop1) void'(q1.pop_front());
    if (pop2) void'(q2.pop_front());
    if (do_push) begin
      if (in_sel) q1.push_back(in_data);
      else        q2.push_back(in_data);
    end
    if (clr) begin
      m_cnt1 = 0;
      m_cnt2 = 0;
    end else if (do_push) begin
      if (in_sel) m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : 65535;
      else        m_cnt2 = (m_cnt2 < 65535) ? m_cnt2 + 1 : 65535;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit s, input logic [31:0] d, input bit r1, input bit r2);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out1_ready = r1;
    out2_ready = r2;
    #1;
  endtask

  task automatic test_reset();
    // Park a word in each channel, then pull reset mid-cycle.
    drive(1, 1, 32'h1111_0001, 0, 0);
    step();
    drive(1, 0, 32'h2222_0001, 0, 0);
    step();
    #2;
    rst = 1'b1;
    q1.delete();
    q2.delete();
    #1;
    checks++;
    if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid got %b%b want 00", out1_valid, out2_valid);
    end
    checks++;
    if (out1_data !== 32'h0 || out2_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h %h want 0 0", out1_data, out2_data);
    end
    for (int s = 0; s < 2; s++) begin
      in_sel = s[0];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_ready sel=%0d got %b want 1", s, in_ready);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_push_stall();
    drive(1, 1, 32'hAAAA_0001, 0, 0);
    step();
    drive(1, 1, 32'hAAAA_0002, 0, 0);
    step();
    drive(0, 1, 32'h0, 0, 0);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'hAAAA_0001) begin
      errors++;
      $display("[TB] FAIL stall_head got v=%b d=%h want v=1 d=aaaa0001", out1_valid, out1_data);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_ready_sel1 got %b want 0", in_ready);
    end
    drive(0, 0, 32'h0, 0, 0);
    checks++;
    if (in_ready !== 1'b1 || out2_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_ch2_untouched got rdy=%b v2=%b want 1 0", in_ready, out2_valid);
    end
    // Drain and confirm order.
    drive(0, 0, 32'h0, 1, 0);
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if (out1_valid !== 1'b1 || out1_data !== (32'hAAAA_0000 + 32'(i))) begin
        errors++;
        $display("[TB] FAIL stall_drain%0d got v=%b d=%h want aaaa000%0d", i, out1_valid, out1_data, i);
      end
      step();
    end
    drive(0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_streaming();
    int bad = 0;
    for (int i = 1; i <= 9; i++) begin
      drive(i <= 8, 0, 32'(i), 0, 1);
      if (i <= 8 && in_ready !== 1'b1) bad++;
      if (i > 1 && (out2_valid !== 1'b1 || out2_data !== 32'(i - 1))) begin
        errors++;
        $display("[TB] FAIL stream_word%0d got v=%b d=%h want %0d", i - 1, out2_valid, out2_data, i - 1);
      end
      if (i > 1) checks++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL stream_ready_drops got %0d want 0", bad);
    end
    drive(0, 0, 32'h0, 0, 0);
    checks++;
    if (out2_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_empty got %b want 0", out2_valid);
    end
  endtask

  task automatic test_interleave();
    logic [31:0] words [4] = '{32'd10, 32'd20, 32'd11, 32'd21};
    for (int i = 0; i < 4; i++) begin
      drive(1, (i % 2) == 0, words[i], 0, 0);
      step();
    end
    drive(0, 0, 32'h0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out1_data !== words[2 * i] || out2_data !== words[2 * i + 1] ||
          out1_valid !== 1'b1 || out2_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL interleave%0d got %0d,%0d want %0d,%0d", i, out1_data, out2_data,
                 words[2 * i], words[2 * i + 1]);
      end
      step();
    end
    drive(0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_full_pop();
    drive(1, 1, 32'h5000_0001, 0, 0);
    step();
    drive(1, 1, 32'h5000_0002, 0, 0);
    step();
    drive(1, 1, 32'h5000_0003, 1, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_pop_ready got %b want 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out1_data !== 32'h5000_0002) begin
      errors++;
      $display("[TB] FAIL full_pop_next got rdy=%b d=%h want 1 50000002", in_ready, out1_data);
    end
    step();
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h5000_0003) begin
      errors++;
      $display("[TB] FAIL full_pop_accept got v=%b d=%h want 50000003", out1_valid, out1_data);
    end
    drive(0, 0, 32'h0, 1, 0);
    step();
    drive(0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_random();
    int bad = 0;
    bit exp_rdy;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      exp_rdy = in_sel ? (q1.size() < 2) : (q2.size() < 2);
      if (in_ready !== exp_rdy) bad++;
      if (out1_valid !== (q1.size() > 0) || out2_valid !== (q2.size() > 0)) bad++;
      if (q1.size() > 0 && out1_data !== q1[0]) bad++;
      if (q2.size() > 0 && out2_data !== q2[0]) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL random_traffic got %0d bad cycles want 0", bad);
    end
    drive(0, 0, 32'h0, 1, 1);
    step();
    step();
    drive(0, 0, 32'h0, 0, 0);
  endtask

`ifdef DEMUX1X2_CNT_EN
  task automatic test_counters();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'(i), 0, 1);
      step();
    end
    checks++;
    if (cnt2 !== 16'(m_cnt2) || m_cnt2 != 3) begin
      errors++;
      $display("[TB] FAIL cnt2_three got %0d want 3", cnt2);
    end
    cnt_clr = 1'b1;
    drive(1, 0, 32'h4, 0, 1);
    step();
    cnt_clr = 1'b0;
    checks++;
    if (cnt2 !== 16'h0) begin
      errors++;
      $display("[TB] FAIL cnt2_clear got %0d want 0", cnt2);
    end
    drive(1, 1, 32'h7, 1, 1);
    for (int i = 0; i < 65535; i++) step();
    checks++;
    if (cnt1 !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL cnt1_preload got %h want ffff", cnt1);
    end
    step();
    checks++;
    if (cnt1 !== 16'hFFFF || m_cnt1 != 65535) begin
      errors++;
      $display("[TB] FAIL cnt1_saturate got %h want ffff", cnt1);
    end
    drive(0, 0, 32'h0, 1, 1);
    step();
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
`ifdef DEMUX1X2_CNT_EN
    cnt_clr = 1'b0;
`endif
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_push_stall();
    test_streaming();
    test_interleave();
    test_full_pop();
    test_random();
`ifdef DEMUX1X2_CNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
